// File: rtl/nes_dma_pkg.sv
// Shared types and default bus addresses for the NES sprite OAM DMA engine.
package nes_dma_pkg;

    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} dma_state_t;

    localparam logic [15:0] DMA_REG_ADDR_DEF  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR_DEF = 16'h2004;
    localparam int unsigned XFER_LEN_DEF      = 256;

endpackage

// File: rtl/nes_oam_dma.sv
// Sprite OAM DMA: on a CPU write to the DMA register, halt the CPU and copy one
// page of memory into the PPU OAM data port as alternating get/put bus cycles.
import nes_dma_pkg::*;

module nes_oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR  = DMA_REG_ADDR_DEF,
    parameter logic [15:0] OAM_DATA_ADDR = OAM_DATA_ADDR_DEF,
    parameter int unsigned XFER_LEN      = XFER_LEN_DEF
) (
    input  logic        clk,
    input  logic        b_rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rw,
    input  logic [7:0]  bus_din,
    output logic        cpu_halt,
    output logic        dma_bus_en,
    output logic [15:0] bus_addr,
    output logic        bus_rw,
    output logic [7:0]  bus_dout,
    output logic        dma_active
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t state, state_nxt;
    logic       parity;
    logic [7:0] idx, idx_nxt;
    logic [7:0] page;
    logic [7:0] latch;
    logic       trigger;

    assign trigger    = (state == IDLE) && !cpu_rw && (cpu_addr == DMA_REG_ADDR);
    // The put-cycle data is the byte latched on the preceding get cycle.
    assign bus_dout   = latch;
    assign dma_active = cpu_halt;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = HALT;
                    idx_nxt   = '0;
                end
            end
            // parity=1 now means the following cycle is a get cycle.
            HALT:  state_nxt = parity ? READ : ALIGN;
            ALIGN: state_nxt = READ;
            READ:  state_nxt = WRITE;
            WRITE: begin
                idx_nxt   = idx + 8'd1;
                state_nxt = (idx == LAST_IDX) ? IDLE : READ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge b_rst) begin
        if (!b_rst) begin
            state      <= IDLE;
            parity     <= 1'b0;
            idx        <= '0;
            page       <= '0;
            latch      <= '0;
            cpu_halt   <= 1'b0;
            dma_bus_en <= 1'b0;
            bus_addr   <= '0;
            bus_rw     <= 1'b1;
        end else begin
            parity <= ~parity;
            state  <= state_nxt;
            idx    <= idx_nxt;
            if (trigger) begin
                page <= cpu_dout;
            end
            if (state == READ) begin
                latch <= bus_din;
            end
            // Bus outputs are decoded from the next state so they are registered.
            cpu_halt   <= (state_nxt != IDLE);
            dma_bus_en <= (state_nxt == READ) || (state_nxt == WRITE);
            bus_rw     <= (state_nxt != WRITE);
            if (state_nxt == READ) begin
                bus_addr <= {page, idx_nxt};
            end else if (state_nxt == WRITE) begin
                bus_addr <= OAM_DATA_ADDR;
            end
        end
    end

endmodule

// File: tb/tb_nes_oam_dma.sv
// Self-checking bench for nes_oam_dma against a transaction-level model of one
// DMA transfer built from a random memory image.
module tb_nes_oam_dma;

    logic        clk;
    logic        b_rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rw;
    logic [7:0]  bus_din;
    logic        cpu_halt;
    logic        dma_bus_en;
    logic [15:0] bus_addr;
    logic        bus_rw;
    logic [7:0]  bus_dout;
    logic        dma_active;

    logic [7:0]  mem [0:65535];
    int unsigned cyc;
    int          n_assert;
    int          n_fail;
    bit          saw_400;

    nes_oam_dma dut (
        .clk        (clk),
        .b_rst      (b_rst),
        .cpu_addr   (cpu_addr),
        .cpu_dout   (cpu_dout),
        .cpu_rw     (cpu_rw),
        .bus_din    (bus_din),
        .cpu_halt   (cpu_halt),
        .dma_bus_en (dma_bus_en),
        .bus_addr   (bus_addr),
        .bus_rw     (bus_rw),
        .bus_dout   (bus_dout),
        .dma_active (dma_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus_din = mem[bus_addr];

    // Edges since reset release; its LSB is the parity of the current cycle.
    always @(posedge clk or negedge b_rst) begin
        if (!b_rst) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (dma_bus_en && bus_addr == 16'h0400) saw_400 <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_halt"}, 32'(cpu_halt), 32'd0);
        chk({tag, "_en"}, 32'(dma_bus_en), 32'd0);
        chk({tag, "_act"}, 32'(dma_active), 32'd0);
    endtask

    // Issue the trigger write and check every cycle of the transfer.
    // mode: 0 = force no ALIGN, 1 = force ALIGN, -1 = trigger immediately.
    // abort_at >= 0 pulls reset during that READ index.
    task automatic run_dma(input logic [7:0] pg, input int mode, input int abort_at,
                           input bit stray);
        bit          align;
        int          halts;
        logic [15:0] a;
        if (mode >= 0 && int'(cyc[0]) != mode) @(negedge clk);
        cpu_addr = 16'h4014;
        cpu_rw   = 1'b0;
        cpu_dout = pg;
        @(negedge clk);
        cpu_addr = 16'h0000;
        cpu_rw   = 1'b1;
        cpu_dout = 8'h00;
        // HALT cycle parity 0 means the next cycle is a put cycle.
        align = (cyc[0] == 1'b0);
        halts = int'(cpu_halt);
        chk("halt_halt", 32'(cpu_halt), 32'd1);
        chk("halt_en", 32'(dma_bus_en), 32'd0);
        chk("halt_act", 32'(dma_active), 32'd1);
        if (align) begin
            @(negedge clk);
            halts += int'(cpu_halt);
            chk("align_halt", 32'(cpu_halt), 32'd1);
            chk("align_en", 32'(dma_bus_en), 32'd0);
        end
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (stray && i == 10) begin
                cpu_addr = 16'h4014;
                cpu_rw   = 1'b0;
                cpu_dout = 8'hEE;
            end
            if (stray && i == 20) begin
                cpu_addr = 16'h0000;
                cpu_rw   = 1'b1;
            end
            a = {pg, 8'(i)};
            halts += int'(cpu_halt);
            chk("rd_halt", 32'(cpu_halt), 32'd1);
            chk("rd_en", 32'(dma_bus_en), 32'd1);
            chk("rd_rw", 32'(bus_rw), 32'd1);
            chk("rd_addr", 32'(bus_addr), 32'(a));
            if (i == abort_at) begin
                #1 b_rst = 1'b0;
                #1;
                chk("rst_halt", 32'(cpu_halt), 32'd0);
                chk("rst_en", 32'(dma_bus_en), 32'd0);
                chk("rst_act", 32'(dma_active), 32'd0);
                chk("rst_addr", 32'(bus_addr), 32'd0);
                chk("rst_rw", 32'(bus_rw), 32'd1);
                chk("rst_dout", 32'(bus_dout), 32'd0);
                return;
            end
            @(negedge clk);
            halts += int'(cpu_halt);
            chk("wr_en", 32'(dma_bus_en), 32'd1);
            chk("wr_rw", 32'(bus_rw), 32'd0);
            chk("wr_addr", 32'(bus_addr), 32'h2004);
            chk("wr_data", 32'(bus_dout), 32'(mem[a]));
        end
        @(negedge clk);
        chk_idle("release");
        chk("release_rw", 32'(bus_rw), 32'd1);
        chk("stall_len", 32'(halts), align ? 32'd514 : 32'd513);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        saw_400  = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        b_rst    = 1'b0;
        cpu_addr = 16'h0000;
        cpu_dout = 8'h00;
        cpu_rw   = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        chk("reset_addr", 32'(bus_addr), 32'd0);
        chk("reset_rw", 32'(bus_rw), 32'd1);
        chk("reset_dout", 32'(bus_dout), 32'd0);
        b_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reads of the trigger register and writes elsewhere do nothing.
        cpu_addr = 16'h4014; cpu_rw = 1'b1; cpu_dout = 8'h55;
        @(negedge clk); chk_idle("nt_rd4014");
        cpu_addr = 16'h4015; cpu_rw = 1'b0;
        @(negedge clk); chk_idle("nt_wr4015");
        cpu_addr = 16'h2004;
        @(negedge clk); chk_idle("nt_wr2004");
        cpu_addr = 16'h0000; cpu_rw = 1'b1;
        @(negedge clk); chk_idle("nt_after");
        @(negedge clk); chk_idle("nt_after2");

        run_dma(8'h02, 0, -1, 1'b0);
        @(negedge clk);
        run_dma(8'h02, 1, -1, 1'b0);

        for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i) ^ 8'hA5;
        saw_400 = 1'b0;
        run_dma(8'h03, -1, -1, 1'b0);
        chk("no_0400", 32'(saw_400), 32'd0);

        run_dma(8'h40, -1, -1, 1'b1);
        run_dma(8'($urandom_range(0, 255)), -1, -1, 1'b0);

        run_dma(8'h05, -1, 99, 1'b0);
        repeat (2) @(negedge clk);
        chk_idle("in_reset");
        b_rst = 1'b1;
        @(negedge clk);
        chk_idle("post_reset");
        run_dma(8'h07, -1, -1, 1'b0);

        run_dma(8'h08, -1, -1, 1'b0);
        run_dma(8'h09, -1, -1, 1'b0);
        @(negedge clk);
        chk_idle("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nes_oam_dma.md
Name: nes_oam_dma

Overview:
- Sprite OAM DMA engine on the NES CPU bus, directly downstream of the 6502 core (NES_CPU); consumes the CPU address/data/rw outputs.
- A CPU write to $4014 with page P makes the engine halt the CPU and take the bus.
- It then copies 256 bytes from $PP00..$PPFF to the PPU OAM data port ($2004) as alternating read/write cycles, then returns the bus to the CPU.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA.
- OAM_DATA_ADDR, 16'h2004, write target for every transferred byte.
- XFER_LEN, 256, bytes per transfer; power of two, at most 256.

Ports:
- clk  in  1  CPU clock; one tick per CPU bus cycle.
- b_rst  in  1  asynchronous active-low reset.
- cpu_addr  in  16  CPU address bus.
- cpu_dout  in  8  CPU write data.
- cpu_rw  in  1  CPU direction: 1 = read, 0 = write.
- bus_din  in  8  read data returned from the system bus in the current cycle.
- cpu_halt  out  1  1 = CPU stalls and tri-states its bus; the CPU honours it on the next cycle.
- dma_bus_en  out  1  1 = the bus mux selects the DMA outputs below.
- bus_addr  out  16  DMA address.
- bus_rw  out  1  DMA direction: 1 = read, 0 = write.
- bus_dout  out  8  DMA write data.
- dma_active  out  1  high from the HALT state through the last write; for debug and the bench.

Behaviour:
- Reset (async assert, sync deassert at the next clk): state IDLE, cpu_halt=0, dma_bus_en=0, bus_addr=0, bus_rw=1, bus_dout=0, dma_active=0, parity=0, idx=0, page=0, latch=0.
- parity flop: toggles every clk unconditionally. 0 = get cycle, 1 = put cycle.
- Trigger: in IDLE, cpu_rw=0 && cpu_addr==DMA_REG_ADDR sampled at a clk edge → page<=cpu_dout, state<=HALT.
- Trigger is ignored in every state other than IDLE. Writes to any other address have no effect.
- HALT (1 cycle): cpu_halt=1, dma_bus_en=0, dma_active=1.
  - Next state is READ if the next cycle is a get cycle (parity will be 0); otherwise ALIGN.
- ALIGN (1 cycle): cpu_halt=1, bus idle (dma_bus_en=0) → READ.
- READ (always on parity 0): dma_bus_en=1, bus_addr={page,idx[7:0]}, bus_rw=1.
  - latch<=bus_din at the end of the cycle → WRITE.
- WRITE (always on parity 1): dma_bus_en=1, bus_addr=OAM_DATA_ADDR, bus_rw=0, bus_dout=latch.
  - idx<=idx+1. If idx==XFER_LEN-1 → IDLE, else → READ.
- idx is 8 bits, cleared on entering HALT. The address stays within page P; no carry into page.
- CPU-visible stall after the trigger cycle: 513 cycles without ALIGN, 514 cycles with ALIGN.
- Release: at the edge leaving the final WRITE, cpu_halt and dma_bus_en drop to 0 together, and bus_rw returns to 1.
- Outputs are registered and change only on a clk edge. In IDLE, bus_addr, bus_dout and latch hold their last values; only the enables matter.
- Reset mid-transfer: immediate IDLE with all reset values; the CPU is released asynchronously. The partial transfer is not resumed.
- Page $40 (reading $4000..$40FF, including $4014 itself) is transferred like any other page. The engine reads only and never re-triggers.

Decomposition:
- nes_dma_pkg holds:
  - typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} dma_state_t;
  - localparams for the default DMA_REG_ADDR and OAM_DATA_ADDR.
- No sub-module. The parity flop, state register and idx counter sit inline; the total is roughly 150 RTL lines.
- Bus ownership is muxed outside this block using dma_bus_en.

Test Plan:
- Trigger at even alignment: CPU writes $4014=0x02 with HALT landing on parity 1 (next cycle get).
  - Expect: no ALIGN, and reads 0x0200..0x02FF interleaved with writes to 0x2004.
  - Expect: bus_dout equals the memory model byte of each preceding read.
  - Expect: cpu_halt high for exactly 513 cycles.
- Odd alignment: same write one cycle later → exactly one ALIGN cycle, dma_bus_en=0 during ALIGN, and cpu_halt high for 514 cycles.
- Data pattern: memory $0300+i = i^0xA5, write $4014=0x03 → the 256 bus_dout values at 0x2004 match in order; the last read address is 0x03FF and no 0x0400 access occurs.
- Non-trigger: CPU reads $4014, and writes 0x55 to $4015 and $2004 → state stays IDLE, cpu_halt=0, dma_bus_en=0 throughout.
- Reset mid-op: assert b_rst low during the 100th READ → cpu_halt and dma_bus_en go to 0 without a clk edge.
  - Expect: after release, a new $4014=0x07 write runs a full transfer starting at 0x0700.
- Back-to-back: a second $4014 write issued one cycle after the last WRITE completes → a new DMA starts correctly, with idx reset to 0.
